// File: rtl/vs_inner_product_engine.sv
// Correlation engine: streams a column-major dictionary against a signal vector
// through one Q15 MAC, emitting one inner product per atom plus the max-|ip| atom.
module vs_inner_product_engine #(
  parameter int SIGNAL_SIZE               = 64,
  parameter int DICTIONARY_SIZE           = 256,
  parameter int FP_Q                      = 15,
  parameter int FP_DATA_BUS_WIDTH         = 32,
  parameter int SIGNAL_ADDR_WIDTH         = (SIGNAL_SIZE > 1) ? $clog2(SIGNAL_SIZE) : 1,
  parameter int DICTIONARY_ADDR_WIDTH     = $clog2(SIGNAL_SIZE * DICTIONARY_SIZE),
  parameter int REPRESENTATION_ADDR_WIDTH = (DICTIONARY_SIZE > 1) ? $clog2(DICTIONARY_SIZE) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [SIGNAL_ADDR_WIDTH-1:0]         y_addr,
  input  logic [FP_DATA_BUS_WIDTH-1:0]         y_data,
  output logic [DICTIONARY_ADDR_WIDTH-1:0]     dict_addr,
  input  logic [FP_DATA_BUS_WIDTH-1:0]         dict_data,
  output logic                                 ip_valid,
  output logic [REPRESENTATION_ADDR_WIDTH-1:0] ip_index,
  output logic [31:0]                          ip_value,
  output logic [REPRESENTATION_ADDR_WIDTH-1:0] best_index,
  output logic [31:0]                          best_abs
);

  localparam int SAW = SIGNAL_ADDR_WIDTH;
  localparam int DAW = DICTIONARY_ADDR_WIDTH;
  localparam int RAW = REPRESENTATION_ADDR_WIDTH;
  localparam int DW  = FP_DATA_BUS_WIDTH;

  localparam logic [SAW-1:0] ROW_LAST   = SAW'(SIGNAL_SIZE - 1);
  localparam logic [DAW-1:0] LIN_PENULT = DAW'(SIGNAL_SIZE * DICTIONARY_SIZE - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     drain_q, drain_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           launch_s, issue_s;

  logic [SAW-1:0] row_q;
  logic [RAW-1:0] col_q;
  logic [DAW-1:0] lin_q;
  logic           v1_q, v2_q, v3_q;
  logic [SAW-1:0] row2_q;
  logic [RAW-1:0] col2_q, col3_q;
  logic           first3_q, last3_q;

  logic signed [63:0] y_ext_s, d_ext_s;
  logic signed [63:0] prod_q;
  logic signed [63:0] acc_q, acc_d;

  logic           ip_valid_q;
  logic [RAW-1:0] ip_index_q;
  logic [31:0]    ip_value_q;
  logic [31:0]    ip_mag_s;
  logic [RAW-1:0] best_index_q;
  logic [31:0]    best_abs_q;

  // Q30 accumulator -> Q15 with floor shift, clamped to the signed 32-bit range.
  function automatic logic [31:0] sat_q15(input logic signed [63:0] acc);
    logic signed [63:0] sh;
    sh = acc >>> FP_Q;
    if (sh > 64'sh0000_0000_7FFF_FFFF) begin
      sat_q15 = 32'h7FFF_FFFF;
    end else if (sh < 64'shFFFF_FFFF_8000_0000) begin
      sat_q15 = 32'h8000_0000;
    end else begin
      sat_q15 = sh[31:0];
    end
  endfunction

  function automatic logic [31:0] abs_q15(input logic [31:0] v);
    if (v == 32'h8000_0000) begin
      abs_q15 = 32'h7FFF_FFFF;
    end else if (v[31]) begin
      abs_q15 = 32'h0000_0000 - v;
    end else begin
      abs_q15 = v;
    end
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // FSM next state and issue control
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    launch_s = 1'b0;
    issue_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          launch_s = 1'b1;
          busy_d   = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      RUN: begin
        issue_s = 1'b1;
        if (lin_q == LIN_PENULT) begin
          state_d = DRAIN;
          drain_d = 2'd0;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd3) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Address generation (row fastest) and tag pipeline alongside the memory read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= {SAW{1'b0}};
      col_q  <= {RAW{1'b0}};
      lin_q  <= {DAW{1'b0}};
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      row2_q <= {SAW{1'b0}};
      col2_q <= {RAW{1'b0}};
    end else begin
      v1_q   <= launch_s | issue_s;
      v2_q   <= v1_q;
      row2_q <= row_q;
      col2_q <= col_q;
      if (launch_s) begin
        row_q <= {SAW{1'b0}};
        col_q <= {RAW{1'b0}};
        lin_q <= {DAW{1'b0}};
      end else if (issue_s) begin
        lin_q <= lin_q + {{(DAW-1){1'b0}}, 1'b1};
        if (row_q == ROW_LAST) begin
          row_q <= {SAW{1'b0}};
          col_q <= col_q + {{(RAW-1){1'b0}}, 1'b1};
        end else begin
          row_q <= row_q + {{(SAW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign y_ext_s = $signed({{(64-DW){y_data[DW-1]}}, y_data});
  assign d_ext_s = $signed({{(64-DW){dict_data[DW-1]}}, dict_data});
  assign acc_d   = first3_q ? prod_q : (acc_q + prod_q);
  assign ip_mag_s = abs_q15(ip_value_q);

  // Product register, row-restarting accumulator and per-atom result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q       <= 1'b0;
      first3_q   <= 1'b0;
      last3_q    <= 1'b0;
      col3_q     <= {RAW{1'b0}};
      prod_q     <= 64'sd0;
      acc_q      <= 64'sd0;
      ip_valid_q <= 1'b0;
      ip_index_q <= {RAW{1'b0}};
      ip_value_q <= 32'h0000_0000;
    end else begin
      v3_q       <= v2_q;
      first3_q   <= (row2_q == {SAW{1'b0}});
      last3_q    <= (row2_q == ROW_LAST);
      col3_q     <= col2_q;
      ip_valid_q <= v3_q & last3_q;
      if (v2_q) begin
        prod_q <= y_ext_s * d_ext_s;
      end
      if (v3_q) begin
        acc_q <= acc_d;
        if (last3_q) begin
          ip_index_q <= col3_q;
          ip_value_q <= sat_q15(acc_d);
        end
      end
    end
  end

  // Running argmax; strict compare keeps the lowest index on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_abs_q   <= 32'h0000_0000;
      best_index_q <= {RAW{1'b0}};
    end else if (launch_s) begin
      best_abs_q   <= 32'h0000_0000;
      best_index_q <= {RAW{1'b0}};
    end else if (ip_valid_q && (ip_mag_s > best_abs_q)) begin
      best_abs_q   <= ip_mag_s;
      best_index_q <= ip_index_q;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign y_addr     = row_q;
  assign dict_addr  = lin_q;
  assign ip_valid   = ip_valid_q;
  assign ip_index   = ip_index_q;
  assign ip_value   = ip_value_q;
  assign best_index = best_index_q;
  assign best_abs   = best_abs_q;

endmodule
